// File: rtl/window_gen_pkg.sv
// Shared types and elaboration-time helpers for the strided window generator.
package window_gen_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_e;

    // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Number of full windows along one dimension.
    function automatic int win_count(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

endpackage

// File: rtl/window_line_buffer.sv
// One raster row of pixel history; combinational read of the entry being overwritten.
module window_line_buffer #(
    parameter int COLS       = 20,
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [COLS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/strided_window_gen.sv
// Raster-in, K x K window-out generator emitting only STRIDE-aligned windows.
module strided_window_gen
    import window_gen_pkg::*;
#(
    parameter int ROWS        = 20,
    parameter int COLS        = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 2
) (
    input  logic                                             clk_100MHz,
    input  logic                                             rst_n,
    input  logic                                             start,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [DATA_WIDTH-1:0]                            in_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]    out_window,
    output logic [cnt_w(ROWS)-1:0]                           out_row,
    output logic [cnt_w(COLS)-1:0]                           out_col,
    output logic                                             busy,
    output logic                                             done
);

    localparam int K  = KERNEL_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int RW = cnt_w(ROWS);
    localparam int CW = cnt_w(COLS);
    localparam int PW = cnt_w(STRIDE);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_EDGE = RW'(K - 1);
    localparam logic [CW-1:0] COL_EDGE = CW'(K - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

    state_e state, state_nxt;

    logic [RW-1:0] row, win_row;
    logic [CW-1:0] col, win_col;
    logic [PW-1:0] row_phase, col_phase;

    logic accept, frame_end, row_ok, col_ok, emit;

    logic [K-2:0][DW-1:0]        lb_rd, lb_wr;
    logic [K-1:0][K-1:0][DW-1:0] win, win_nxt;

    assign in_ready  = (state == ACTIVE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign frame_end = accept && (row == ROW_LAST) && (col == COL_LAST);
    assign row_ok    = (row >= ROW_EDGE);
    assign col_ok    = (col >= COL_EDGE);
    assign emit      = accept && row_ok && col_ok && (row_phase == '0) && (col_phase == '0);

    // Line buffer 0 holds the previous row; buffer i holds the row i+1 above it.
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
        if (gi == 0) begin : g_head
            assign lb_wr[gi] = in_data;
        end else begin : g_tail
            assign lb_wr[gi] = lb_rd[gi-1];
        end
        window_line_buffer #(
            .COLS       (COLS),
            .DATA_WIDTH (DW),
            .AW         (CW)
        ) u_lb (
            .clk   (clk_100MHz),
            .we    (accept),
            .addr  (col),
            .wdata (lb_wr[gi]),
            .rdata (lb_rd[gi])
        );
    end

    always_comb begin
        win_nxt = win;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_nxt[r][K-1] = lb_rd[K-2-r];
        end
        win_nxt[K-1][K-1] = in_data;
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = ACTIVE;
            ACTIVE: begin
                busy = 1'b1;
                if (frame_end) state_nxt = DRAIN;
            end
            // Leave once the output register is empty or emptying this cycle.
            DRAIN: begin
                busy = 1'b1;
                if (!out_valid || out_ready) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            row_phase <= '0;
            col_phase <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (state == IDLE && start) begin
            row       <= '0;
            col       <= '0;
            row_phase <= '0;
            col_phase <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col       <= '0;
                col_phase <= '0;
                win_col   <= '0;
                if (row == ROW_LAST) begin
                    row       <= '0;
                    row_phase <= '0;
                    win_row   <= '0;
                end else begin
                    row <= row + RW'(1);
                    // Phases stay at 0 until the first full window edge is reached.
                    if (row_ok)
                        row_phase <= (row_phase == PH_LAST) ? '0 : row_phase + PW'(1);
                    if (row_ok && row_phase == '0)
                        win_row <= win_row + RW'(1);
                end
            end else begin
                col <= col + CW'(1);
                if (col_ok)
                    col_phase <= (col_phase == PH_LAST) ? '0 : col_phase + PW'(1);
                if (emit)
                    win_col <= win_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            win        <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            if (accept) win <= win_nxt;
            if (emit) begin
                out_valid  <= 1'b1;
                out_window <= win_nxt;
                out_row    <= win_row;
                out_col    <= win_col;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
